// File: rtl/cp0_intc_pkg.sv
// Shared CP0 register numbers, status/cause bit positions and exception codes
// for the coprocessor-0 / interrupt controller slice.
package cp0_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int SR_IE    = 0;
    localparam int SR_EXL   = 1;
    localparam int CAUSE_BD = 31;

    localparam logic [4:0] EXC_INT = 5'd0;

endpackage

// File: rtl/cp0_intc_irq_sync_edge.sv
// One interrupt channel: optional synchroniser chain, rising-edge detector and
// sticky pending bit; ip presents either the pending bit or the synced level.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 0,
    parameter bit IS_EDGE     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic rawIn,
    input  logic clrPend,
    output logic ip
);

    logic syncd;
    logic prev;
    logic pending;

    generate
        if (SYNC_STAGES == 0) begin : gNoSync
            assign syncd = rawIn;
        end else begin : gSync
            logic [SYNC_STAGES-1:0] chain;
            always_ff @(posedge clk) begin
                if (reset) begin
                    chain <= '0;
                end else begin
                    chain[0] <= rawIn;
                    for (int k = 1; k < SYNC_STAGES; k++) chain[k] <= chain[k-1];
                end
            end
            assign syncd = chain[SYNC_STAGES-1];
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would let prev see the new syncd.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev    <= 1'b0;
            pending <= 1'b0;
        end else begin
            prev <= syncd;
            // A new edge in the same cycle as a software clear keeps the bit set.
            if (syncd && !prev) pending <= 1'b1;
            else if (clrPend)   pending <= 1'b0;
        end
    end

    assign ip = IS_EDGE ? pending : syncd;

endmodule

// File: rtl/cp0_intc.sv
// Coprocessor 0 for the 5-stage core: SR/Cause/EPC/PrID, prioritised hardware
// interrupts and synchronous exception capture beside the M stage.
module cp0_intc
    import cp0_pkg::*;
#(
    parameter int          NUM_IRQ     = 6,
    parameter int          IRQ_BASE    = 10,
    parameter logic [7:0]  EDGE_MASK   = 8'h00,
    parameter int          SYNC_STAGES = 0,
    parameter logic [31:0] PRID        = 32'h0000_4D50
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               we_i,
    input  logic [4:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    input  logic [31:0]        pc_i,
    input  logic               bd_i,
    input  logic               exc_req_i,
    input  logic [4:0]         exc_code_i,
    input  logic               eret_i,
    input  logic [NUM_IRQ-1:0] hw_int_i,
    output logic               int_req_o,
    output logic [2:0]         int_idx_o,
    output logic [31:0]        epc_o,
    output logic               exl_o
);

    logic               srIe;
    logic               srExl;
    logic [NUM_IRQ-1:0] srIm;
    logic               causeBd;
    logic [4:0]         excCode;
    logic [29:0]        epcHi;

    logic [NUM_IRQ-1:0] ipVec;
    logic [NUM_IRQ-1:0] ipEn;
    logic [NUM_IRQ-1:0] clrPend;
    logic               irq;
    logic               take;
    logic [31:0]        excPc;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : gChan
        // Only edge channels hold state, so only they react to a Cause write.
        assign clrPend[i] = we_i && !take && (addr_i == CP0_CAUSE) && !wdata_i[IRQ_BASE+i];

        irq_sync_edge #(
            .SYNC_STAGES(SYNC_STAGES),
            .IS_EDGE    (EDGE_MASK[i])
        ) uSyncEdge (
            .clk    (clk),
            .reset  (reset),
            .rawIn  (hw_int_i[i]),
            .clrPend(clrPend[i]),
            .ip     (ipVec[i])
        );
    end

    assign ipEn      = ipVec & srIm;
    assign irq       = srIe && !srExl && (|ipEn);
    assign take      = !reset && (exc_req_i || irq);
    assign int_req_o = take;
    assign excPc     = bd_i ? (pc_i - 32'd4) : pc_i;
    assign epc_o     = {epcHi, 2'b00};
    assign exl_o     = srExl;

    // NOTE: every combinational output gets a default before the case/loop so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        int_idx_o = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (ipEn[i]) int_idx_o = 3'(i);
        end
    end

    always_comb begin
        rdata_o = '0;
        case (addr_i)
            CP0_SR: begin
                rdata_o[SR_IE]                = srIe;
                rdata_o[SR_EXL]               = srExl;
                rdata_o[IRQ_BASE +: NUM_IRQ]  = srIm;
            end
            CP0_CAUSE: begin
                rdata_o[CAUSE_BD]             = causeBd;
                rdata_o[IRQ_BASE +: NUM_IRQ]  = ipVec;
                rdata_o[6:2]                  = excCode;
            end
            CP0_EPC:  rdata_o = {epcHi, 2'b00};
            CP0_PRID: rdata_o = PRID;
            default:  ;
        endcase
    end

    // A take outranks ERET and discards any MTC0 issued in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            srIe    <= 1'b0;
            srExl   <= 1'b0;
            srIm    <= '0;
            causeBd <= 1'b0;
            excCode <= EXC_INT;
            epcHi   <= '0;
        end else if (take) begin
            srExl   <= 1'b1;
            causeBd <= bd_i;
            epcHi   <= excPc[31:2];
            excCode <= exc_req_i ? exc_code_i : EXC_INT;
        end else begin
            if (eret_i) srExl <= 1'b0;
            if (we_i) begin
                case (addr_i)
                    CP0_SR: begin
                        srIe  <= wdata_i[SR_IE];
                        srExl <= wdata_i[SR_EXL];
                        srIm  <= wdata_i[IRQ_BASE +: NUM_IRQ];
                    end
                    CP0_EPC: epcHi <= wdata_i[31:2];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc: one instance with an edge channel 0 and one with
// a two-flop synchroniser, checked through a queue of expected values.
module tb_cp0_intc;

    logic        clk;
    logic        reset;
    logic        we_i;
    logic [4:0]  addr_i;
    logic [31:0] wdata_i;
    logic [31:0] pc_i;
    logic        bd_i;
    logic        exc_req_i;
    logic [4:0]  exc_code_i;
    logic        eret_i;
    logic [5:0]  hw0, hw1;
    logic [31:0] rdata0, rdata1, epc0, epc1;
    logic        intReq0, intReq1, exl0, exl1;
    logic [2:0]  intIdx0, intIdx1;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sbItem;

    sbItem sb[$];
    int    errors = 0;
    int    checks = 0;

    cp0_intc #(.NUM_IRQ(6), .IRQ_BASE(10), .EDGE_MASK(8'h01), .SYNC_STAGES(0)) dut0 (
        .clk(clk), .reset(reset), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rdata_o(rdata0), .pc_i(pc_i), .bd_i(bd_i), .exc_req_i(exc_req_i),
        .exc_code_i(exc_code_i), .eret_i(eret_i), .hw_int_i(hw0), .int_req_o(intReq0),
        .int_idx_o(intIdx0), .epc_o(epc0), .exl_o(exl0)
    );

    cp0_intc #(.NUM_IRQ(6), .IRQ_BASE(10), .EDGE_MASK(8'h00), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .reset(reset), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .rdata_o(rdata1), .pc_i(pc_i), .bd_i(bd_i), .exc_req_i(exc_req_i),
        .exc_code_i(exc_code_i), .eret_i(eret_i), .hw_int_i(hw1), .int_req_o(intReq1),
        .int_idx_o(intIdx1), .epc_o(epc1), .exl_o(exl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] val);
        sbItem e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        sbItem e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard-empty observed=%h expected=<none>", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we_i    = 1'b1;
        addr_i  = a;
        wdata_i = d;
        tick();
        we_i    = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        addr_i = a;
        #1;
    endtask

    task automatic eret();
        eret_i = 1'b1;
        tick();
        eret_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1; we_i = 1'b0; addr_i = '0; wdata_i = '0; pc_i = '0; bd_i = 1'b0;
        exc_req_i = 1'b0; exc_code_i = '0; eret_i = 1'b0; hw0 = '0; hw1 = '0;
        tick();
        tick();

        // Reset state; an exception request is masked while reset is high.
        exc_req_i = 1'b1; #1;
        push("rst int_req", 0); check(intReq0);
        exc_req_i = 1'b0;
        rd(12); push("rst SR", 0); check(rdata0);
        rd(13); push("rst Cause", 0); check(rdata0);
        push("rst EPC", 0); check(epc0);
        reset = 1'b0;
        tick();

        // Level interrupt on channel 3, not in a delay slot.
        mtc0(12, 32'h0000_FC01);
        rd(12); push("t1 SR", 32'h0000_FC01); check(rdata0);
        hw0 = 6'b001000; pc_i = 32'h3008; bd_i = 1'b0; #1;
        push("t1 int_req", 1); check(intReq0);
        push("t1 idx", 3); check(intIdx0);
        tick();
        push("t1 exl", 1); check(exl0);
        push("t1 epc", 32'h3008); check(epc0);
        rd(13); push("t1 Cause", 32'h0000_2000); check(rdata0);
        push("t1 gated", 0); check(intReq0);
        hw0 = '0;
        eret();
        push("t1 eret exl", 0); check(exl0);

        // Same take from a branch delay slot.
        hw0 = 6'b001000; pc_i = 32'h300C; bd_i = 1'b1; #1;
        push("t2 int_req", 1); check(intReq0);
        tick();
        push("t2 epc", 32'h3008); check(epc0);
        rd(13); push("t2 Cause", 32'h8000_2000); check(rdata0);
        hw0 = '0;
        eret();

        // Edge channel 0: sticky while IE = 0, then taken once IE is set.
        mtc0(12, 32'h0000_FC00);
        hw0 = 6'b000001; tick();
        hw0 = '0; #1;
        rd(13); push("t3 sticky", 32'h8000_0400); check(rdata0);
        push("t3 ie0", 0); check(intReq0);
        pc_i = 32'h4000; bd_i = 1'b0;
        mtc0(12, 32'h0000_FC01);
        push("t3 int_req", 1); check(intReq0);
        push("t3 idx", 0); check(intIdx0);
        mtc0(13, 32'h0);
        rd(13); push("t3 write dropped", 32'h0000_0400); check(rdata0);
        push("t3 epc", 32'h4000); check(epc0);
        mtc0(13, 32'h0);
        rd(13); push("t3 clear", 0); check(rdata0);
        hw0 = 6'b000001;
        mtc0(13, 32'h0);
        hw0 = '0;
        rd(13); push("t3 set wins", 32'h0000_0400); check(rdata0);
        mtc0(13, 32'h0);
        rd(13); push("t3 reclear", 0); check(rdata0);
        eret();
        push("t3 idle", 0); check(intReq0);

        // Synchronous exception alongside a pending interrupt on channel 5.
        hw0 = 6'b100000; exc_req_i = 1'b1; exc_code_i = 5'd12; pc_i = 32'h5000; #1;
        push("t4 int_req", 1); check(intReq0);
        push("t4 idx", 5); check(intIdx0);
        tick();
        exc_req_i = 1'b0; exc_code_i = '0;
        push("t4 exl", 1); check(exl0);
        rd(13); push("t4 Cause", 32'h0000_8030); check(rdata0);
        push("t4 gated", 0); check(intReq0);
        eret();
        push("t4 eret exl", 0); check(exl0);
        push("t4 after eret", 1); check(intReq0);
        push("t4 after idx", 5); check(intIdx0);
        hw0 = '0;

        // EXL blocks the interrupt; MTC0 EPC and ERET share a cycle.
        hw0 = 6'b010000; pc_i = 32'h6000; tick();
        push("t5 exl gate", 0); check(intReq0);
        push("t5 idx", 4); check(intIdx0);
        eret_i = 1'b1;
        mtc0(14, 32'h1234_5677);
        eret_i = 1'b0;
        push("t5 epc", 32'h1234_5674); check(epc0);
        push("t5 exl", 0); check(exl0);
        push("t5 int_req", 1); check(intReq0);
        hw0 = '0;

        // PrID is read-only, unmapped reads are 0, SR hides unused bits.
        rd(15); push("prid", 32'h0000_4D50); check(rdata0);
        mtc0(15, 32'h0);
        rd(15); push("prid ro", 32'h0000_4D50); check(rdata0);
        rd(3); push("unmapped", 0); check(rdata0);
        mtc0(12, 32'hFFFF_FFFF);
        rd(12); push("SR mask", 32'h0000_FC03); check(rdata0);

        // Reset mid-operation drops a pending edge.
        hw0 = 6'b000001; tick();
        hw0 = '0;
        rd(13); push("pre-rst pend", 32'h0000_0400); check(rdata0);
        reset = 1'b1; tick();
        reset = 1'b0;
        rd(13); push("mid rst Cause", 0); check(rdata0);
        rd(12); push("mid rst SR", 0); check(rdata0);

        // Two-stage synchroniser delays a level input by two cycles.
        mtc0(12, 32'h0000_FC01);
        hw1 = 6'b000100; #1;
        push("t6 t+0", 0); check(intReq1);
        tick();
        push("t6 t+1", 0); check(intReq1);
        tick();
        push("t6 t+2", 1); check(intReq1);
        push("t6 idx", 2); check(intIdx1);
        hw1 = '0;
        rd(15); push("t6 prid", 32'h0000_4D50); check(rdata1);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard-leftover observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cp0_intc.md
Name: cp0_intc

Overview:
- Parametrised coprocessor-0 and interrupt controller for the 5-stage MIPS core.
- Supports N hardware interrupt channels with per-channel level/edge mode, optional input synchronisers, a priority-encoded cause index and synchronous-exception capture.
- Holds SR, Cause, EPC and PrID.
- Sits beside the M stage: the pipeline issues MFC0/MTC0/ERET there, and `int_req_o` flushes D/E/M and redirects F to the handler.

Parameters:
- NUM_IRQ, 6: hardware interrupt channels, 1..8.
- IRQ_BASE, 10: bit position of channel 0 in SR.IM and Cause.IP. IRQ_BASE+NUM_IRQ must be ≤ 16.
- EDGE_MASK, 0: bit i = 1 makes channel i rising-edge, sticky. Otherwise the channel is level-sensitive.
- SYNC_STAGES, 0: synchroniser flops per hw_int_i bit, 0..3.
- PRID, 32'h0000_4D50: value read at address 15.

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-high; clock clk.
- we_i, in, 1: MTC0 write enable.
- addr_i, in, 5: CP0 register number for both read and write.
- wdata_i, in, 32: MTC0 data.
- rdata_o, out, 32: MFC0 data, combinational from addr_i.
- pc_i, in, 32: PC of the instruction in M.
- bd_i, in, 1: the M instruction sits in a branch delay slot.
- exc_req_i, in, 1: synchronous exception request from M.
- exc_code_i, in, 5: ExcCode for exc_req_i.
- eret_i, in, 1: ERET in M.
- hw_int_i, in, NUM_IRQ: raw device interrupt lines.
- int_req_o, out, 1: take exception/interrupt this cycle, combinational.
- int_idx_o, out, 3: highest pending enabled channel.
- epc_o, out, 32: current EPC.
- exl_o, out, 1: SR.EXL.

Behaviour:
- Register map (reads; unmapped addresses read 0):
  - 12 SR: bit0 IE, bit1 EXL, IM at [IRQ_BASE+NUM_IRQ-1:IRQ_BASE]; all other bits read 0.
  - 13 Cause: bit31 BD, IP field at the IM positions, ExcCode at [6:2].
  - 14 EPC.
  - 15 PrID (read-only, equals PRID).
- Reset: SR, Cause, EPC, edge pending bits and synchroniser flops all go to 0. int_req_o = 0 while reset is high, regardless of exc_req_i.
- Synchroniser: hw_int_i passes through SYNC_STAGES flops to give s[i]. With SYNC_STAGES = 0, s = hw_int_i combinationally.
- Level channel: IP[i] = s[i], not stored.
- Edge channel:
  - prev[i] is registered s[i].
  - Pending sets on s[i] & ~prev[i].
  - Pending clears only on an MTC0 to Cause with that IP bit = 0.
  - Set wins over clear in the same cycle.
- Interrupt condition: irq = IE & ~EXL & |(IP & IM).
- int_req_o = exc_req_i | irq. A synchronous exception is taken even with EXL = 1; only interrupts are gated.
- int_idx_o: highest-numbered channel with IP & IM set; 0 when none. Valid regardless of IE/EXL.
- Take (int_req_o = 1), registered at the next edge:
  - EXL ← 1.
  - BD ← bd_i.
  - EPC ← bd_i ? pc_i−4 : pc_i, with bits [1:0] forced to 0.
  - ExcCode ← exc_req_i ? exc_code_i : 0.
- Simultaneous events:
  - exc_req_i together with irq: the exception's code is recorded; the interrupt stays pending and is taken after ERET.
  - Take together with eret_i: take wins, ERET is ignored.
  - Take together with we_i: the write is discarded entirely.
- ERET (no take): EXL ← 0 next cycle. A pending interrupt asserts int_req_o in the following cycle at the earliest.
- MTC0 (no take):
  - SR: writes IE, EXL and IM.
  - Cause: writes only the edge-channel IP bits (clear only). BD, ExcCode and level IP are read-only.
  - EPC: writes bits [31:2]; bits [1:0] stay 0.
  - PrID and unmapped addresses: write ignored.
- Reset mid-operation: all state clears within the cycle; any pending edge is lost.

Decomposition:
- Package cp0_pkg holds:
  - Register numbers CP0_SR = 12, CP0_CAUSE = 13, CP0_EPC = 14, CP0_PRID = 15.
  - SR bit indices SR_IE = 0, SR_EXL = 1.
  - CAUSE_BD = 31, EXC_INT = 5'd0.
- One sub-module, irq_sync_edge: per-channel synchroniser plus edge detector and sticky pending bit, generated NUM_IRQ times.

Test Plan:
1. Reset, then SR = 0x0000_FC01, NUM_IRQ = 6, level channel 3 raised, pc_i = 0x3008, bd_i = 0 → int_req_o = 1 the same cycle, int_idx_o = 3. Next cycle: EXL = 1, EPC = 0x3008, Cause = 0x0000_2000 with ExcCode 0.
2. Same take with bd_i = 1, pc_i = 0x300C → EPC = 0x3008, Cause bit31 = 1.
3. Edge channel 0 (EDGE_MASK = 1), one-cycle pulse with IE = 0 → IP0 stays 1. Set IE → int_req_o asserts. MTC0 Cause = 0 → IP0 reads 0.
4. exc_req_i = 1, exc_code_i = 12, with channel 5 pending and enabled → ExcCode = 12, EXL = 1. After ERET, int_req_o = 1 with int_idx_o = 5.
5. EXL = 1 with an interrupt pending → int_req_o = 0. Same cycle, we_i to EPC plus eret_i → EPC updated, EXL = 0. Next cycle int_req_o = 1.
6. SYNC_STAGES = 2, level input raised at cycle t → int_req_o first asserts at t+2. Read addr 15 → PRID. Write addr 15 → no change.
